branch_cond_unit: RTL

//   Consumer end of the 16-bit magnitude comparator's less/greater/equal outputs.
//   - Registers the comparator flags into a flag register.
//   - Accepts branch requests (condition code, PC, signed offset) over a valid/ready handshake.
//   - Evaluates the condition against the registered flags.
//   - Returns the next PC and a taken indication over a second valid/ready handshake.

---
 rtl/branch_cond_unit.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/branch_cond_unit.sv
// Branch condition unit: registers comparator flags, evaluates branch requests
// against them and returns the next PC over a valid/ready handshake.
module branch_cond_unit #(
  parameter int unsigned PC_W  = 16,
  parameter int unsigned OFF_W = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flag_valid,
  input  logic             flag_less,
  input  logic             flag_greater,
  input  logic             flag_equal,
  input  logic             flush,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       br_cond,
  input  logic [PC_W-1:0]  br_pc,
  input  logic [OFF_W-1:0] br_off,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             taken,
  output logic [2:0]       flags_q,
  output logic             flag_err,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  state_t             state_q, state_d;
  logic [2:0]         flags_d;
  logic               flags_vld_q, flags_vld_d;
  logic               flag_err_q, flag_err_d;
  logic [2:0]         cond_q, cond_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [OFF_W-1:0]   off_q, off_d;
  logic               taken_q, taken_d;
  logic [PC_W-1:0]    redirect_pc_q, redirect_pc_d;
  logic               redirect_valid_q, redirect_valid_d;
  logic [CNT_W-1:0]   taken_cnt_q, taken_cnt_d;

  logic               flags_onehot_c;
  logic               cond_hit_c;
  logic [PC_W-1:0]    off_ext_c;
  logic               redirect_fire_c;

  assign br_ready       = (state_q == IDLE) && flags_vld_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign taken          = taken_q;
  assign flag_err       = flag_err_q;
  assign taken_cnt      = taken_cnt_q;

  assign flags_onehot_c = ( flag_less & ~flag_greater & ~flag_equal) |
                          (~flag_less &  flag_greater & ~flag_equal) |
                          (~flag_less & ~flag_greater &  flag_equal);
  assign off_ext_c       = {{(PC_W-OFF_W){off_q[OFF_W-1]}}, off_q};
  assign redirect_fire_c = redirect_valid_q && redirect_ready;

  // flags_q bit order is {less, greater, equal}
  always_comb begin
    cond_hit_c = 1'b0;
    case (cond_q)
      3'b000:  cond_hit_c = 1'b1;
      3'b001:  cond_hit_c = flags_q[0];
      3'b010:  cond_hit_c = ~flags_q[0];
      3'b011:  cond_hit_c = flags_q[2];
      3'b100:  cond_hit_c = flags_q[1];
      3'b101:  cond_hit_c = flags_q[2] | flags_q[0];
      3'b110:  cond_hit_c = flags_q[1] | flags_q[0];
      default: cond_hit_c = 1'b0;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    flags_d          = flags_q;
    flags_vld_d      = flags_vld_q;
    flag_err_d       = flag_err_q;
    cond_d           = cond_q;
    pc_d             = pc_q;
    off_d            = off_q;
    taken_d          = taken_q;
    redirect_pc_d    = redirect_pc_q;
    redirect_valid_d = redirect_valid_q;
    taken_cnt_d      = taken_cnt_q;

    if (flag_valid) begin
      if (flags_onehot_c) begin
        flags_d     = {flag_less, flag_greater, flag_equal};
        flags_vld_d = 1'b1;
      end else begin
        flag_err_d  = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (!flush && br_valid && br_ready) begin
          cond_d  = br_cond;
          pc_d    = br_pc;
          off_d   = br_off;
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          taken_d       = cond_hit_c;
          redirect_pc_d = cond_hit_c ? pc_q + off_ext_c : pc_q + PC_W'(1);
          state_d       = RESP;
        end
      end
      RESP: begin
        // valid rises one cycle after entering RESP; a completed transfer wins over flush
        if (redirect_fire_c) begin
          taken_cnt_d      = taken_cnt_q + CNT_W'(taken_q);
          redirect_valid_d = 1'b0;
          state_d          = IDLE;
        end else if (flush) begin
          redirect_valid_d = 1'b0;
          state_d          = IDLE;
        end else begin
          redirect_valid_d = 1'b1;
        end
      end
      default: begin
        redirect_valid_d = 1'b0;
        state_d          = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      flags_q          <= '0;
      flags_vld_q      <= 1'b0;
      flag_err_q       <= 1'b0;
      cond_q           <= '0;
      pc_q             <= '0;
      off_q            <= '0;
      taken_q          <= 1'b0;
      redirect_pc_q    <= '0;
      redirect_valid_q <= 1'b0;
      taken_cnt_q      <= '0;
    end else begin
      state_q          <= state_d;
      flags_q          <= flags_d;
      flags_vld_q      <= flags_vld_d;
      flag_err_q       <= flag_err_d;
      cond_q           <= cond_d;
      pc_q             <= pc_d;
      off_q            <= off_d;
      taken_q          <= taken_d;
      redirect_pc_q    <= redirect_pc_d;
      redirect_valid_q <= redirect_valid_d;
      taken_cnt_q      <= taken_cnt_d;
    end
  end

endmodule
